// File: rtl/spi_frame_rx.sv
// spi_frame_rx
//   SPI (mode 0) slave receive front-end feeding the measurement-collection
//   stage. SCK/MOSI/SSEL are synchronised into the clk domain. Received bits
//   are assembled MSB-first into words. Each word produces a one-cycle strobe
//   with its position in the frame, and the last word of a frame also produces
//   a frame strobe. A status word is shifted out on MISO while data arrives.
//
// Ports
//   clk            system clock, at least 4x the SCK frequency
//   rst            synchronous active-high reset
//   SCK            SPI clock (asynchronous, idle low)
//   MOSI           SPI data in (asynchronous)
//   SSEL           SPI slave select, active low (asynchronous)
//   MISO           SPI data out, driven low while deselected
//   tx_byte        status word, sampled at every transmit load
//   byte_received  one-cycle strobe: data_byte holds a new word
//   data_byte      last completed word, held until the next one
//   byte_index     position within the frame of the word in data_byte
//   frame_done     one-cycle strobe with byte_received of word FRAME_LEN-1
//   overrun        sticky: a word was cut short by SSEL deassertion
//
// Handshake: byte_received and frame_done are pure strobes with no ready.
// The consumer must take data_byte/byte_index in the strobe cycle or before
// the next strobe; there is no backpressure.
module spi_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              SSEL,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_byte,
  output logic              byte_received,
  output logic [DATA_W-1:0] data_byte,
  output logic [IDX_W-1:0]  byte_index,
  output logic              frame_done,
  output logic              overrun
);

  localparam int BIT_W = $clog2(DATA_W);

  // Two-flop synchronisers; index 1 is the synchronised value.
  logic [1:0] sck_sync;
  logic [1:0] ssel_sync;
  logic [1:0] mosi_sync;
  logic       sck_hist;
  logic       ssel_hist;

  logic sck_rise;
  logic sck_fall;
  logic ssel_active;
  logic ssel_start;
  logic ssel_end;
  logic capture;
  logic last_bit;

  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [IDX_W-1:0]  frame_cnt;
  logic              word_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      ssel_sync <= 2'b11;
      mosi_sync <= 2'b00;
      sck_hist  <= 1'b0;
      ssel_hist <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], SCK};
      ssel_sync <= {ssel_sync[0], SSEL};
      mosi_sync <= {mosi_sync[0], MOSI};
      sck_hist  <= sck_sync[1];
      ssel_hist <= ssel_sync[1];
    end
  end

  always_comb begin
    sck_rise    = ~sck_hist & sck_sync[1];
    sck_fall    = sck_hist & ~sck_sync[1];
    ssel_active = ~ssel_sync[1];
    ssel_start  = ssel_hist & ~ssel_sync[1];
    ssel_end    = ~ssel_hist & ssel_sync[1];
    // ssel_end takes priority over a coincident SCK rise.
    capture     = sck_rise & ssel_active & ~ssel_end;
    last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
  end

  // Receive path and word completion. The bit that finishes a word sets
  // word_done; the word is published one clk later.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= '0;
      shift_reg     <= '0;
      word_done     <= 1'b0;
      frame_cnt     <= '0;
      data_byte     <= '0;
      byte_index    <= '0;
      byte_received <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      byte_received <= 1'b0;
      frame_done    <= 1'b0;
      word_done     <= 1'b0;

      if (ssel_end) begin
        // A partially received word is dropped without a strobe.
        if (bit_cnt != '0) overrun <= 1'b1;
        bit_cnt <= '0;
      end else if (capture) begin
        shift_reg <= {shift_reg[DATA_W-2:0], mosi_sync[1]};
        if (last_bit) begin
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (word_done) begin
        data_byte     <= shift_reg;
        byte_received <= 1'b1;
        byte_index    <= frame_cnt;
        frame_done    <= (frame_cnt == IDX_W'(FRAME_LEN - 1));
        // FRAME_LEN is a power of two, so the counter wraps on its own.
        // It is deliberately untouched by SSEL so frames may span bursts.
        frame_cnt     <= frame_cnt + 1'b1;
      end
    end
  end

  // Transmit path. The falling SCK edge that follows the last bit of a word
  // must not shift, otherwise the freshly loaded MSB of the next status word
  // would be lost. bit_cnt is 0 exactly in that gap, so shifts are gated on
  // a non-zero bit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg <= '0;
    end else if (ssel_start || (word_done && ssel_active)) begin
      tx_reg <= tx_byte;
    end else if (sck_fall && ssel_active && (bit_cnt != '0)) begin
      tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
    end
  end

  assign MISO = ssel_active & tx_reg[DATA_W-1];

endmodule

// File: tb/tb_spi_frame_rx.sv
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SCK = 1'b0;
  logic       MOSI = 1'b0;
  logic       SSEL = 1'b1;
  logic       MISO;
  logic [7:0] tx_byte = 8'h00;
  logic       byte_received;
  logic [7:0] data_byte;
  logic [5:0] byte_index;
  logic       frame_done;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frame = 0;

  // {frame_done, byte_index, data_byte}
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];
  logic [7:0]  miso_cap;

  spi_frame_rx #(.DATA_W(8), .FRAME_LEN(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL), .MISO(MISO),
    .tx_byte(tx_byte), .byte_received(byte_received), .data_byte(data_byte),
    .byte_index(byte_index), .frame_done(frame_done), .overrun(overrun)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    obs_q.delete();
    exp_q.delete();
    exp_frame = 0;
  endtask

  // Observe every strobe cycle; a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (byte_received || frame_done)
      obs_q.push_back({frame_done, byte_index, data_byte});
  end

  // Drivers: SCK = clk/8, MOSI set mid-low phase, MISO sampled at SCK rise.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = b[7-i];
      wait_clk(4);
      SCK = 1'b1;
      miso_cap[7-i] = MISO;
      wait_clk(4);
      SCK = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back({(exp_frame == 63), 6'(exp_frame), b});
    exp_frame = (exp_frame + 1) % 64;
  endtask

  task automatic ssel_low();
    SSEL = 1'b0;
    wait_clk(4);
  endtask

  task automatic ssel_high();
    wait_clk(2);
    SSEL = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_reset();
    SSEL = 1'b1;
    do_reset();
    n_cmp++;
    if ({byte_received, frame_done, overrun, MISO} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {byte_received, frame_done, overrun, MISO});
    end
    n_cmp++;
    if ({byte_index, data_byte} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_data: got idx=%0d data=%h want 0/00", byte_index, data_byte);
    end
  endtask

  task automatic test_single();
    ssel_low();
    expect_byte(8'hA5);
    send_byte(8'hA5);
    ssel_high();
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_bad++;
      $display("FAIL single_count: got %0d want 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [14:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single_word: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL single_overrun: got %b want 0", overrun);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame();
    do_reset();
    ssel_low();
    for (int i = 0; i < 64; i++) begin
      expect_byte(8'(i));
      send_byte(8'(i));
    end
    expect_byte(8'h77);
    send_byte(8'h77);
    ssel_high();
    n_cmp++;
    if (obs_q.size() !== 65) begin
      n_bad++;
      $display("FAIL frame_count: got %0d want 65", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [14:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL frame_word: got %h want %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_miso();
    tx_byte = 8'hC3;
    ssel_low();
    expect_byte(8'h00);
    send_byte(8'h00);
    n_cmp++;
    if (miso_cap !== 8'hC3) begin
      n_bad++;
      $display("FAIL miso_bits: got %b want 11000011", miso_cap);
    end
    ssel_high();
    n_cmp++;
    if (MISO !== 1'b0) begin
      n_bad++;
      $display("FAIL miso_idle: got %b want 0", MISO);
    end
    n_cmp++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL miso_word: got n=%0d %h want %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 15'h0, exp_q[0]);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_overrun: got %b want 0", overrun);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overrun();
    ssel_low();
    send_bits(8'hFF, 5);
    ssel_high();
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL partial_strobe: got %0d strobes want 0", obs_q.size());
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    ssel_low();
    expect_byte(8'h12);
    send_byte(8'h12);
    ssel_high();
    n_cmp++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL after_overrun: got n=%0d %h want %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 15'h0, exp_q[0]);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_split_frame();
    do_reset();
    ssel_low();
    for (int i = 0; i < 10; i++) begin
      expect_byte(8'(8'h80 + i));
      send_byte(8'(8'h80 + i));
    end
    ssel_high();
    ssel_low();
    for (int i = 0; i < 54; i++) begin
      expect_byte(8'(8'h20 + i));
      send_byte(8'(8'h20 + i));
    end
    ssel_high();
    n_cmp++;
    if (obs_q.size() !== 64) begin
      n_bad++;
      $display("FAIL split_count: got %0d want 64", obs_q.size());
    end
    n_cmp++;
    if (obs_q.size() > 0 && obs_q[obs_q.size()-1] !== {1'b1, 6'd63, 8'h55}) begin
      n_bad++;
      $display("FAIL split_last: got %h want %h", obs_q[obs_q.size()-1], {1'b1, 6'd63, 8'h55});
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [14:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL split_word: got %h want %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_word();
    // Start from a non-zero frame position with overrun set.
    ssel_low();
    send_byte(8'h01);
    ssel_high();
    ssel_low();
    send_bits(8'h01, 2);
    ssel_high();
    ssel_low();
    send_bits(8'hFF, 3);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    exp_frame = 0;
    wait_clk(4);
    expect_byte(8'h5A);
    send_byte(8'h5A);
    ssel_high();
    n_cmp++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL rst_mid_word: got n=%0d %h want %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 15'h0, exp_q[0]);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_overrun: got %b want 0", overrun);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    wait_clk(1);
    test_reset();
    test_single();
    test_frame();
    test_miso();
    test_overrun();
    test_split_frame();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- SPI slave receive front-end, directly upstream of the measurement-collection stage.
- Synchronises the raw SCK/MOSI/SSEL pins into the system clock domain and assembles MSB-first bytes (SPI mode 0).
- Emits one-cycle byte strobes, a byte index, and a frame-complete strobe every FRAME_LEN bytes.
- Shifts a status byte out on MISO in parallel with reception.

Parameters:
- DATA_W, 8, bits per SPI word.
- FRAME_LEN, 64, words per compressed-measurement frame; must be a power of two, at least 2.
- IDX_W, 6, width of byte_index; equals log2(FRAME_LEN).

Ports:
- clk  input  1  system clock; must run at least 4x the SCK frequency.
- rst  input  1  synchronous, active-high reset.
- SCK  input  1  SPI clock, asynchronous to clk, idle low.
- MOSI  input  1  SPI data in, asynchronous.
- SSEL  input  1  SPI slave select, active low, asynchronous.
- MISO  output  1  SPI data out.
- tx_byte  input  DATA_W  status word returned to the master; sampled at each word load.
- byte_received  output  1  one-cycle strobe: data_byte holds a new word.
- data_byte  output  DATA_W  last completed word; held until the next word.
- byte_index  output  IDX_W  position within the frame of the word now in data_byte.
- frame_done  output  1  one-cycle strobe coincident with byte_received of word FRAME_LEN-1.
- overrun  output  1  sticky flag: a word was cut short by SSEL deassertion; cleared only by rst.

Behaviour:
- Reset:
  - rst is sampled on the clk rising edge.
  - byte_received=0, frame_done=0, overrun=0, data_byte=0, byte_index=0, MISO=0.
  - Synchroniser history is reset to SCK=0, SSEL=1.
  - Bit counter=0; frame counter=0.
- Synchronisation: SCK, MOSI and SSEL each pass through 2 flops, then 1 history flop for edge detect.
  - sck_rise = (history, current) == (0, 1).
  - sck_fall = (history, current) == (1, 0).
  - ssel_active = synchronised SSEL == 0.
  - ssel_start / ssel_end = falling / rising edge of synchronised SSEL.
- Receive:
  - On sck_rise with ssel_active, shift synchronised MOSI into the shift register LSB; first bit received is the MSB.
  - The bit counter runs 0..DATA_W-1.
- Word completion: the sck_rise that captures bit DATA_W-1 causes, on the next clk edge:
  - data_byte = assembled word;
  - byte_received = 1 for exactly one cycle;
  - byte_index = frame counter value;
  - then the frame counter increments;
  - bit counter returns to 0.
- Latency: byte_received rises on the 4th clk rising edge after the first edge that samples SCK=1 on the last bit.
- Frame:
  - When the completed word has index FRAME_LEN-1, frame_done pulses in the same cycle as byte_received.
  - The frame counter wraps to 0.
  - The frame counter is NOT reset by SSEL, so a frame may span multiple SSEL bursts.
- Transmit:
  - On ssel_start, and on each word completion while ssel_active, tx_byte is loaded into the transmit register.
  - MISO = transmit MSB immediately after the load.
  - On each sck_fall with ssel_active, the transmit register shifts left; MISO presents the next bit.
  - While SSEL is inactive, MISO = 0.
- SSEL deassert mid-word (ssel_end with bit counter not 0):
  - The partial word is discarded; no strobe is issued.
  - Bit counter = 0; overrun = 1.
  - The frame counter is unchanged.
- ssel_end with bit counter 0: no effect beyond idling MISO.
- SCK edges while SSEL is inactive are ignored completely.
- Simultaneous events:
  - sck_rise and ssel_end in the same cycle: ssel_end wins; the bit is not captured.
  - rst overrides everything.
- Reset mid-word: all state returns to reset values; the next word starts at bit 0, index 0.

Test Plan:
1. Reset, SSEL low, send 0xA5 with SCK at clk/8 -> one byte_received pulse, data_byte=0xA5, byte_index=0, frame_done=0, overrun=0.
2. Send bytes 0x00..0x3F in one SSEL burst -> 64 strobes, byte_index 0..63 matches the data; frame_done high only with 0x3F; 65th byte 0x77 -> byte_index=0, frame_done=0.
3. tx_byte=0xC3 held, master sends 0x00 -> MISO bits sampled on SCK rising read 1,1,0,0,0,0,1,1; MISO=0 after SSEL is raised.
4. SSEL raised after 5 bits of 0xFF, then a full byte 0x12 -> no strobe for the partial word; overrun=1; next strobe data_byte=0x12 with byte_index unchanged from before.
5. 10 bytes sent, SSEL raised, 54 bytes sent in a second burst -> frame_done on the 64th byte overall, byte_index=63.
6. rst asserted for one cycle after 3 bits of a word, then 0x5A sent -> data_byte=0x5A, byte_index=0, overrun=0, exactly one strobe.
